// File: rtl/io_pkg.sv
// Shared types and defaults for the OUT/IN peripheral port controller.
package io_pkg;

  // Default width of port and pipeline data.
  localparam int unsigned IO_DATA_W = 16;

  // Input-path FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } in_state_e;

endpackage

// File: rtl/io_out_fifo.sv
// Output queue between execute (OUT) and the external output port.
// A push is admitted only against the registered count, so a pop in the
// same cycle never frees room for a push in that cycle.
module io_out_fifo
  import io_pkg::*;
#(
  parameter int unsigned DATA_W = IO_DATA_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Status from the registered count and qualified push/pop strobes.
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty    = (count == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // Gate with empty so the port shows zero when nothing is queued.
    pop_data = empty ? '0 : mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Peripheral end of the OUT/IN instructions: queues OUT words toward the
// output port and fetches one input-port word per IN, stalling execute
// while either side cannot complete.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DATA_W    = IO_DATA_W,
  parameter int unsigned OUT_DEPTH = 4,
  localparam int unsigned CNT_W    = $clog2(OUT_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_en,
  input  logic [DATA_W-1:0] out_data,
  input  logic              in_en,
  output logic [DATA_W-1:0] in_data,
  output logic              in_done,
  output logic              stall,
  output logic [DATA_W-1:0] port_out_data,
  output logic              port_out_valid,
  input  logic              port_out_ready,
  input  logic [DATA_W-1:0] port_in_data,
  input  logic              port_in_valid,
  output logic              port_in_ready,
  output logic [CNT_W-1:0]  out_count
);

  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_pop;
  logic      in_stall;
  logic      capture;
  in_state_e state_q;
  in_state_e state_d;

  io_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_en),
    .push_data (out_data),
    .pop       (fifo_pop),
    .pop_data  (port_out_data),
    .count     (out_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output handshake and combined stall.
  always_comb begin
    port_out_valid = !fifo_empty;
    fifo_pop       = port_out_valid && port_out_ready;
    stall          = (out_en && fifo_full) || in_stall;
  end

  // IN FSM: drain earlier OUTs, then take one input word, then release.
  always_comb begin
    state_d       = state_q;
    in_stall      = 1'b0;
    port_in_ready = 1'b0;
    in_done       = 1'b0;
    capture       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_en) begin
          in_stall = 1'b1;
          // With out_en also high the OUT goes first and the IN waits here.
          if (!out_en) state_d = fifo_empty ? StWait : StDrain;
        end
      end
      StDrain: begin
        in_stall = 1'b1;
        if (!in_en) begin
          state_d = StIdle;
        end else if (fifo_empty) begin
          state_d = StWait;
        end
      end
      StWait: begin
        in_stall = 1'b1;
        if (!in_en) begin
          state_d = StIdle;
        end else begin
          // Ready only while the IN is live, so a flush never eats a word.
          port_in_ready = 1'b1;
          if (port_in_valid) begin
            capture = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        in_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Returned IN word; holds until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_data <= '0;
    end else if (capture) begin
      in_data <= port_in_data;
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_io_port_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          out_en;
  logic [DW-1:0] out_data;
  logic          in_en;
  logic [DW-1:0] in_data;
  logic          in_done;
  logic          stall;
  logic [DW-1:0] port_out_data;
  logic          port_out_valid;
  logic          port_out_ready;
  logic [DW-1:0] port_in_data;
  logic          port_in_valid;
  logic          port_in_ready;
  logic [2:0]    out_count;

  io_port_ctrl #(
    .DATA_W    (DW),
    .OUT_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .out_en         (out_en),
    .out_data       (out_data),
    .in_en          (in_en),
    .in_data        (in_data),
    .in_done        (in_done),
    .stall          (stall),
    .port_out_data  (port_out_data),
    .port_out_valid (port_out_valid),
    .port_out_ready (port_out_ready),
    .port_in_data   (port_in_data),
    .port_in_valid  (port_in_valid),
    .port_in_ready  (port_in_ready),
    .out_count      (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural model: queued OUT words plus the progress of one IN.
  logic [DW-1:0] mq[$];
  bit            m_busy;     // IN accepted and not yet retired
  bit            m_ord;      // all earlier OUTs have left; input may be sampled
  bit            m_got;      // word captured, delivered this cycle
  logic [DW-1:0] m_in_data;
  bit            last_stall;
  logic [DW-1:0] seen_q[$];  // words observed leaving the output port

  task automatic model_reset();
    mq.delete();
    m_busy    = 1'b0;
    m_ord     = 1'b0;
    m_got     = 1'b0;
    m_in_data = '0;
  endtask

  task automatic sample_and_check();
    int            cnt;
    logic [DW-1:0] e_pd;
    bit            e_stall;
    bit            e_ready;
    @(negedge clk);
    cnt     = mq.size();
    e_pd    = (cnt != 0) ? mq[0] : '0;
    e_stall = (out_en && cnt == DEPTH) || (in_en && !m_busy) || (m_busy && !m_got);
    e_ready = m_busy && m_ord && !m_got && in_en;
    check("valid",    32'(port_out_valid), 32'(cnt != 0));
    check("pdata",    32'(port_out_data),  32'(e_pd));
    check("count",    32'(out_count),      32'(cnt));
    check("stall",    32'(stall),          32'(e_stall));
    check("in_ready", 32'(port_in_ready),  32'(e_ready));
    check("in_done",  32'(in_done),        32'(m_got));
    check("in_data",  32'(in_data),        32'(m_in_data));
    last_stall = e_stall;
    if (port_out_valid && port_out_ready) seen_q.push_back(port_out_data);
  endtask

  task automatic model_update();
    int cnt;
    bit do_pop;
    bit do_push;
    cnt     = mq.size();
    do_pop  = (cnt != 0) && port_out_ready;
    do_push = out_en && (cnt < DEPTH);
    if (m_got) begin
      m_busy = 1'b0;
      m_got  = 1'b0;
      m_ord  = 1'b0;
    end else if (m_busy) begin
      if (!in_en) begin
        m_busy = 1'b0;
        m_ord  = 1'b0;
      end else if (m_ord) begin
        if (port_in_valid) begin
          m_got     = 1'b1;
          m_in_data = port_in_data;
        end
      end else if (cnt == 0) begin
        m_ord = 1'b1;
      end
    end else if (in_en && !out_en) begin
      m_busy = 1'b1;
      m_ord  = (cnt == 0);
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(out_data);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    sample_and_check();
    advance();
  endtask

  bit            cur_out;
  bit            cur_in;
  logic [DW-1:0] cur_data;
  int            r;

  initial begin
    rst = 1'b0; out_en = 1'b0; out_data = '0; in_en = 1'b0;
    port_out_ready = 1'b0; port_in_data = '0; port_in_valid = 1'b0;
    model_reset();
    last_stall = 1'b0;

    // Power-on reset.
    #2 rst = 1'b1;
    #1;
    check("rst_valid",    32'(port_out_valid), 32'd0);
    check("rst_count",    32'(out_count),      32'd0);
    check("rst_pdata",    32'(port_out_data),  32'd0);
    check("rst_in_data",  32'(in_data),        32'd0);
    check("rst_in_done",  32'(in_done),        32'd0);
    check("rst_in_ready", 32'(port_in_ready),  32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Single OUT straight through.
    out_en = 1'b1; out_data = 16'hA5A5; port_out_ready = 1'b1;
    step();
    out_en = 1'b0;
    sample_and_check();
    check("a5_data",  32'(port_out_data),  32'h0000A5A5);
    check("a5_valid", 32'(port_out_valid), 32'd1);
    advance();
    sample_and_check();
    check("a5_count", 32'(out_count), 32'd0);
    advance();

    // Backpressure until full, then release.
    seen_q.delete();
    port_out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      out_en = 1'b1; out_data = DW'(v);
      sample_and_check();
      check("bp_stall", 32'(stall), (v == 5) ? 32'd1 : 32'd0);
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      sample_and_check();
      check("bp_hold_data",  32'(port_out_data), 32'd1);
      check("bp_hold_stall", 32'(stall),         32'd1);
      check("bp_full_count", 32'(out_count),     32'd4);
      advance();
    end
    port_out_ready = 1'b1;
    sample_and_check();
    check("bp_pop_no_admit", 32'(stall), 32'd1);
    advance();
    sample_and_check();
    check("bp_admit5", 32'(stall), 32'd0);
    advance();
    out_en = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("bp_seen_n", 32'(seen_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++)
      check("bp_order", 32'(seen_q[i]), 32'(i + 1));

    // IN fast path.
    port_out_ready = 1'b0;
    port_in_valid = 1'b1; port_in_data = 16'hBEEF; in_en = 1'b1;
    sample_and_check();
    check("fast_c0_ready", 32'(port_in_ready), 32'd0);
    check("fast_c0_stall", 32'(stall),         32'd1);
    advance();
    sample_and_check();
    check("fast_c1_ready", 32'(port_in_ready), 32'd1);
    advance();
    sample_and_check();
    check("fast_c2_done",  32'(in_done), 32'd1);
    check("fast_c2_data",  32'(in_data), 32'h0000BEEF);
    check("fast_c2_stall", 32'(stall),   32'd0);
    advance();
    in_en = 1'b0; port_in_valid = 1'b0;
    step();

    // IN behind a queued OUT.
    seen_q.delete();
    out_en = 1'b1; out_data = 16'h1234;
    step();
    out_en = 1'b0; in_en = 1'b1; port_in_valid = 1'b1; port_in_data = 16'h5A5A;
    step();
    for (int k = 0; k < 3; k++) begin
      sample_and_check();
      check("drain_ready", 32'(port_in_ready), 32'd0);
      check("drain_stall", 32'(stall),         32'd1);
      check("drain_pdata", 32'(port_out_data), 32'h00001234);
      advance();
    end
    port_out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      sample_and_check();
      if (m_got) break;
      advance();
    end
    check("after_out_done", 32'(in_done), 32'd1);
    check("after_out_data", 32'(in_data), 32'h00005A5A);
    check("after_out_n",    32'(seen_q.size()), 32'd1);
    if (seen_q.size() > 0) check("after_out_first", 32'(seen_q[0]), 32'h00001234);
    advance();
    in_en = 1'b0; port_in_valid = 1'b0;
    step();

    // Back-to-back OUTs across pointer wrap.
    seen_q.delete();
    port_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      out_en = 1'b1; out_data = DW'(16'hC000 + i);
      sample_and_check();
      check("wrap_count_le1", 32'(out_count <= 1), 32'd1);
      advance();
    end
    out_en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("wrap_seen_n", 32'(seen_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < seen_q.size(); i++)
      check("wrap_order", 32'(seen_q[i]), 32'(16'hC000 + i));

    // Asynchronous reset with words queued.
    port_out_ready = 1'b0;
    out_en = 1'b1; out_data = 16'h1111; step();
    out_data = 16'h2222; step();
    out_en = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_valid",   32'(port_out_valid), 32'd0);
    check("arst_count",   32'(out_count),      32'd0);
    check("arst_in_data", 32'(in_data),        32'd0);
    check("arst_pdata",   32'(port_out_data),  32'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Random traffic obeying the hold-while-stalled pipeline rule.
    cur_out = 1'b0; cur_in = 1'b0; cur_data = '0; last_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_en = cur_out; in_en = cur_in; out_data = cur_data;
      port_out_ready = ($urandom % 10) < 6;
      port_in_valid  = $urandom % 2;
      port_in_data   = DW'($urandom);
      step();
      if (!last_stall) begin
        r = $urandom % 100;
        cur_out  = (r < 40);
        cur_in   = (r >= 40) && (r < 55);
        cur_data = DW'($urandom);
      end else if (cur_in && m_busy && !m_got && ($urandom % 25 == 0)) begin
        cur_in = 1'b0;  // pipeline flush of the pending IN
      end
    end
    out_en = 1'b0; in_en = 1'b0; port_out_ready = 1'b1; port_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Peripheral-side end of the OUT/IN one-operand instructions.
- Accepts OUT data from execute into an output queue and drives it to the external output port with a valid/ready handshake.
- Services IN instructions by fetching one word from the external input port through a ready/valid handshake and returning it to the pipeline.
- Stalls execute while either side cannot complete.

Parameters:
- DATA_W, 16, width of the port data and pipeline data.
- OUT_DEPTH, 4, output queue entries (power of 2, at least 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- out_en  in  1  OUT instruction in execute; held high by the pipeline while stall=1.
- out_data  in  DATA_W  Rds value for OUT.
- in_en  in  1  IN instruction in execute; held high while stall=1.
- in_data  out  DATA_W  word returned for IN; registered.
- in_done  out  1  one-cycle pulse; in_data is valid in this cycle.
- stall  out  1  combinational; pipeline must hold the current instruction.
- port_out_data  out  DATA_W  head of the output queue.
- port_out_valid  out  1  queue not empty.
- port_out_ready  in  1  external sink accepts the word.
- port_in_data  in  DATA_W  external input word.
- port_in_valid  in  1  external source has a word.
- port_in_ready  out  1  block will take port_in_data this cycle.
- out_count  out  clog2(OUT_DEPTH)+1  current queue occupancy.

Behaviour:
Reset (async, rst=1):
- Queue empty, out_count=0, port_out_valid=0, port_out_data=0.
- in_data=0, in_done=0, port_in_ready=0, FSM=IDLE.
- Reset mid-transfer discards queued words and any in-flight IN. No partial handshake survives reset.

Output path:
- Push when out_en=1 and count<OUT_DEPTH. One word per cycle. Latency: the word is visible on port_out_data the next cycle if the queue was empty.
- Pop when port_out_valid && port_out_ready.
- port_out_data and port_out_valid must not change while valid=1 and ready=0.
- Full: stall = out_en && (count==OUT_DEPTH). Fullness uses the registered count; a pop in the same cycle does not admit the push. The push happens the following cycle.
- Push and pop in the same cycle (not full): count unchanged, order preserved.
- Read and write pointers wrap modulo OUT_DEPTH.

Input path FSM, states IDLE, DRAIN, WAIT, DONE:
- IDLE:
  - in_en=1 and out_en=0 and queue empty -> WAIT.
  - in_en=1 and out_en=0 and queue not empty -> DRAIN.
  - stall=1 whenever in_en=1.
- DRAIN: stall=1. Stay until the queue is empty, then go to WAIT. This keeps I/O ordering: all earlier OUTs leave before an IN is sampled.
- WAIT: port_in_ready=1, stall=1. On port_in_valid=1: in_data<=port_in_data, go to DONE.
- DONE: in_done=1, stall=0 (the pipeline advances), go to IDLE. port_in_ready=0.
- Minimum IN latency with an empty queue and valid already high: in_en at cycle 0, handshake at cycle 1, in_done and stall low at cycle 2.
- in_en and out_en together (illegal by ISA): OUT is serviced, the FSM stays in IDLE, and stall=1 holds the IN.
- in_en dropping outside DONE (flush): return to IDLE from DRAIN or WAIT. Any captured word is discarded; no handshake is lost because capture only happens on a ready&&valid cycle.
- in_data holds its last value until the next capture.

stall = output-full term OR input FSM term (as above).

Decomposition:
- Package io_pkg: DATA_W default; FSM state encoding (IDLE=2'd0, DRAIN=2'd1, WAIT=2'd2, DONE=2'd3).
- Sub-module io_out_fifo: a synchronous FIFO with the push/pop/count/full/empty rules above.
- io_port_ctrl instantiates io_out_fifo and contains the IN FSM and the stall logic.

Test Plan:
- Reset during traffic: queue holds 2 words, assert rst -> port_out_valid=0, out_count=0, in_data=16'h0000 immediately (async).
- Single OUT: out_data=16'hA5A5 pulse, port_out_ready=1 -> port_out_data=16'hA5A5, valid for 1 cycle, count returns to 0.
- Backpressure and full: port_out_ready=0, push 16'h0001..16'h0005 -> first 4 queued, stall=1 on the 5th. Raise ready -> output order 1,2,3,4,5; data stable while ready=0; the 5th is accepted one cycle after the first pop.
- IN fast path: queue empty, port_in_valid=1, port_in_data=16'hBEEF, in_en at cycle 0 -> port_in_ready at cycle 1, in_done=1 and in_data=16'hBEEF at cycle 2, stall=0 at cycle 2.
- IN after OUT: OUT 16'h1234 with ready=0, then IN -> FSM in DRAIN, port_in_ready=0. Raise ready -> 16'h1234 drains first, then IN completes with port_in_data.
- Wrap-around and simultaneous push/pop: 10 back-to-back OUTs with ready=1 -> count stays at most 1, 10 words out in order, pointers wrap with no loss.
